pf_ingress_arbiter: RTL and testbench
=====================================

// Module: pf_ingress_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter sharing the single packet-filter datapath
//  between NUM_PORTS ingress streams (Avalon-ST style valid/ready/sop/eop).
//  Sits between the ingress port adapters and the filter core inside soc_system.
//  The HPS drives cfg_port_en; the arbiter owns stall-abort and orphan-flush recovery.
// PARAMETERS
//  NUM_PORTS  4    number of ingress requesters (2..8)
//  DATA_W     32   beat width, bits
//  STALL_MAX  256  idle cycles allowed mid-packet on the granted port before abort
// PORTS
//  clk          in   1                  single clock, all logic on rising edge
//  reset_n      in   1                  asynchronous, active-low reset
//  cfg_port_en  in   NUM_PORTS          per-port arbitration enable (HPS register)
//  in_valid     in   NUM_PORTS          per-port beat valid
//  in_sop       in   NUM_PORTS          per-port start of packet
//  in_eop       in   NUM_PORTS          per-port end of packet
//  in_data      in   NUM_PORTS*DATA_W   per-port data, port i at [i*DATA_W +: DATA_W]
//  in_ready     out  NUM_PORTS          per-port ready
//  out_valid    out  1                  beat valid to filter core
//  out_sop      out  1                  start of packet
//  out_eop      out  1                  end of packet
//  out_err      out  1                  aborted-packet marker, valid with out_eop
//  out_data     out  DATA_W             beat data
//  out_port     out  $clog2(NUM_PORTS)  source port of current packet
//  out_ready    in   1                  backpressure from filter core
//  stat_aborts  out  16                 stall-abort count, saturating
//  stat_orphans out  16                 flushed non-sop beats in IDLE, saturating
// BEHAVIOUR
//  - Reset: state=IDLE, grant=0, rr_ptr=NUM_PORTS-1 (port 0 wins first), stall_cnt=0,
//    stats=0; all outputs 0 except out_data/out_port (0).
//  - Beat = valid & ready on the same edge. FSM states IDLE, PASS, ABORT, DRAIN.
//  - IDLE: req[i] = in_valid[i] & in_sop[i] & cfg_port_en[i]. Winner = first set req
//    searching rr_ptr+1, rr_ptr+2, ... modulo NUM_PORTS. Register grant; go PASS next
//    cycle (1-cycle arbitration bubble). No request: stay IDLE. in_ready[i]=1 only for
//    valid & !sop ports (orphan flush, stat_orphans+1 per beat, all ports); else 0.
//  - PASS: out_{valid,sop,eop,data} = in_*[grant] combinationally; in_ready[grant] =
//    out_ready, others 0; out_port=grant; out_err=0. Zero-latency passthrough.
//    Beat with eop -> IDLE, rr_ptr<=grant. cfg_port_en change mid-packet ignored.
//  - stall_cnt: increments each PASS cycle with in_valid[grant]=0, clears on any
//    in_valid[grant]=1 cycle and on state entry. Backpressure (out_ready=0) never stalls.
//    stall_cnt==STALL_MAX-1 and still idle -> ABORT, stat_aborts+1.
//  - ABORT: out_valid=1, out_eop=1, out_err=1, out_sop=0, out_data=0, in_ready=0;
//    hold until out_ready, then DRAIN.
//  - DRAIN: out_valid=0; in_ready[grant]=1; discard beats until an eop beat -> IDLE,
//    rr_ptr<=grant. A sop beat in DRAIN is discarded like any other.
//  - Eop beat and stall threshold on same cycle: eop wins, no abort.
//  - Single-beat packet (sop&eop) legal in PASS. Stats saturate at 16'hFFFF.
//  - Reset mid-packet: immediate return to reset values; downstream sees truncation.
// STRUCTURE
//  - pf_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_PASS, ARB_ABORT, ARB_DRAIN},
//    PF_DATA_W default, stat counter width constant.
//  - Sub-module pf_rr_pick: combinational rotating priority picker
//    (req, rr_ptr -> valid, index); reusable by the egress scheduler.
// TESTING
//  1 Ports 0..3 all present sop at once, 2-beat packets, out_ready=1 -> out_port
//    sequence 0,1,2,3, each packet preceded by exactly one bubble cycle.
//  2 Port 1 sends 5-beat packet, out_ready toggles 1,0 -> 5 beats in order,
//    in_ready[1]==out_ready every PASS cycle, no abort, stat_aborts=0.
//  3 Port 2 stops valid after beat 2 for 256 cycles -> one out_eop&out_err beat,
//    stat_aborts=1, remaining port-2 beats dropped to eop, then IDLE.
//  4 cfg_port_en=4'b1010, ports 0..3 request -> only ports 1,3 granted;
//    clear en[1] mid-packet -> that packet still completes.
//  5 Port 3 drives 3 valid non-sop beats in IDLE -> in_ready[3]=1, stat_orphans=3,
//    out_valid stays 0.
//  6 Assert reset_n=0 mid-PASS on port 1 -> all outputs 0 next sample; after
//    release, port 0 request wins before port 1.

Source files
------------

// File: rtl/pf_pkg.sv
// Shared types and constants for the packet-filter ingress path.
// Also holds the saturating statistics adder used by the arbiter counters.
package pf_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_PASS  = 2'd1,
      ARB_ABORT = 2'd2,
      ARB_DRAIN = 2'd3
   } arb_state_e;

   localparam int PF_DATA_W = 32;
   localparam int PF_STAT_W = 16;

   // Statistics stick at all-ones rather than wrapping.
   function automatic logic [PF_STAT_W-1:0] stat_sat_add(input logic [PF_STAT_W-1:0] cnt,
                                                         input int unsigned          inc);
      int unsigned sum;
      sum = 32'(cnt) + inc;
      if (sum > 32'({PF_STAT_W{1'b1}}))
         return {PF_STAT_W{1'b1}};
      return PF_STAT_W'(sum);
   endfunction

endpackage

// File: rtl/pf_rr_pick.sv
// Combinational rotating-priority picker: first set request after rr_ptr_i,
// wrapping modulo N. Shared with the egress scheduler.
module pf_rr_pick #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] rr_ptr_i,
   output logic         valid_o,
   output logic [W-1:0] index_o
);

   logic [W-1:0] cand;

   always_comb begin
      valid_o = 1'b0;
      index_o = '0;
      cand    = '0;
      // The pointer itself is searched last, so the previous winner yields.
      for (int k = 1; k <= N; k++) begin
         cand = W'((int'(rr_ptr_i) + k) % N);
         if (!valid_o && req_i[cand]) begin
            valid_o = 1'b1;
            index_o = cand;
         end
      end
   end

endmodule

// File: rtl/pf_ingress_arbiter.sv
// Packet-granular round-robin arbiter in front of the filter core, with
// stall-abort of hung packets and flushing of orphan beats while idle.
module pf_ingress_arbiter
   import pf_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = PF_DATA_W,
   parameter int STALL_MAX = 256
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_PORTS-1:0]          cfg_port_en,
   input  logic [NUM_PORTS-1:0]          in_valid,
   input  logic [NUM_PORTS-1:0]          in_sop,
   input  logic [NUM_PORTS-1:0]          in_eop,
   input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
   output logic [NUM_PORTS-1:0]          in_ready,
   output logic                          out_valid,
   output logic                          out_sop,
   output logic                          out_eop,
   output logic                          out_err,
   output logic [DATA_W-1:0]             out_data,
   output logic [$clog2(NUM_PORTS)-1:0]  out_port,
   input  logic                          out_ready,
   output logic [PF_STAT_W-1:0]          stat_aborts,
   output logic [PF_STAT_W-1:0]          stat_orphans
);

   localparam int IDX_W   = $clog2(NUM_PORTS);
   localparam int STALL_W = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;

   arb_state_e             state_q,   state_d;
   logic [IDX_W-1:0]       grant_q,   grant_d;
   logic [IDX_W-1:0]       rr_ptr_q,  rr_ptr_d;
   logic [STALL_W-1:0]     stall_q,   stall_d;
   logic [PF_STAT_W-1:0]   aborts_q,  aborts_d;
   logic [PF_STAT_W-1:0]   orphans_q, orphans_d;

   logic [NUM_PORTS-1:0]   req;
   logic [NUM_PORTS-1:0]   orphan;
   int unsigned            orphan_cnt;
   logic                   pick_vld;
   logic [IDX_W-1:0]       pick_idx;
   logic [NUM_PORTS-1:0]   rdy;

   logic                   g_valid, g_sop, g_eop;
   logic [DATA_W-1:0]      g_data;

   assign req    = in_valid & in_sop & cfg_port_en;
   assign orphan = in_valid & ~in_sop;

   pf_rr_pick #(.N(NUM_PORTS), .W(IDX_W)) u_pick (
      .req_i    (req),
      .rr_ptr_i (rr_ptr_q),
      .valid_o  (pick_vld),
      .index_o  (pick_idx)
   );

   assign g_valid = in_valid[grant_q];
   assign g_sop   = in_sop[grant_q];
   assign g_eop   = in_eop[grant_q];
   assign g_data  = in_data[int'(grant_q)*DATA_W +: DATA_W];

   always_comb begin
      orphan_cnt = 0;
      for (int i = 0; i < NUM_PORTS; i++)
         orphan_cnt = orphan_cnt + 32'(orphan[i]);
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      stall_d   = stall_q;
      aborts_d  = aborts_q;
      orphans_d = orphans_q;
      rdy       = '0;
      out_valid = 1'b0;
      out_sop   = 1'b0;
      out_eop   = 1'b0;
      out_err   = 1'b0;
      out_data  = '0;

      case (state_q)
         ARB_IDLE: begin
            // Non-sop beats have no packet to belong to; swallow them.
            rdy       = orphan;
            orphans_d = stat_sat_add(orphans_q, orphan_cnt);
            stall_d   = '0;
            if (pick_vld) begin
               grant_d = pick_idx;
               state_d = ARB_PASS;
            end
         end

         ARB_PASS: begin
            out_valid     = g_valid;
            out_sop       = g_sop;
            out_eop       = g_eop;
            out_data      = g_data;
            rdy[grant_q]  = out_ready;
            if (g_valid) begin
               // Backpressure is not a source stall, so any valid beat resets the timer.
               stall_d = '0;
               if (out_ready && g_eop) begin
                  state_d  = ARB_IDLE;
                  rr_ptr_d = grant_q;
               end
            end else if (stall_q == STALL_W'(STALL_MAX - 1)) begin
               stall_d  = '0;
               state_d  = ARB_ABORT;
               aborts_d = stat_sat_add(aborts_q, 1);
            end else begin
               stall_d = stall_q + 1'b1;
            end
         end

         ARB_ABORT: begin
            out_valid = 1'b1;
            out_eop   = 1'b1;
            out_err   = 1'b1;
            if (out_ready)
               state_d = ARB_DRAIN;
         end

         ARB_DRAIN: begin
            rdy[grant_q] = 1'b1;
            if (g_valid && g_eop) begin
               state_d  = ARB_IDLE;
               rr_ptr_d = grant_q;
            end
         end

         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ARB_IDLE;
         grant_q   <= '0;
         rr_ptr_q  <= IDX_W'(NUM_PORTS - 1);
         stall_q   <= '0;
         aborts_q  <= '0;
         orphans_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         stall_q   <= stall_d;
         aborts_q  <= aborts_d;
         orphans_q <= orphans_d;
      end
   end

   // Ready is held low while reset is asserted so no beat is consumed.
   assign in_ready     = reset_n ? rdy : '0;
   assign out_port     = grant_q;
   assign stat_aborts  = aborts_q;
   assign stat_orphans = orphans_q;

endmodule

// File: tb/tb_pf_ingress_arbiter.sv
// Directed bench for pf_ingress_arbiter: a per-cycle vector table for
// arbitration/orphan/enable cases plus hand sequences for multi-cycle cases.
module tb_pf_ingress_arbiter;
   import pf_pkg::*;

   localparam int NP = 4;
   localparam int DW = 32;
   localparam int SM = 256;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NP-1:0]     cfg_port_en, in_valid, in_sop, in_eop, in_ready;
   logic [NP*DW-1:0]  in_data;
   logic              out_valid, out_sop, out_eop, out_err, out_ready;
   logic [DW-1:0]     out_data;
   logic [1:0]        out_port;
   logic [15:0]       stat_aborts, stat_orphans;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pf_ingress_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .STALL_MAX(SM)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cfg_port_en  (cfg_port_en),
      .in_valid     (in_valid),
      .in_sop       (in_sop),
      .in_eop       (in_eop),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_sop      (out_sop),
      .out_eop      (out_eop),
      .out_err      (out_err),
      .out_data     (out_data),
      .out_port     (out_port),
      .out_ready    (out_ready),
      .stat_aborts  (stat_aborts),
      .stat_orphans (stat_orphans)
   );

   // exp layout: {valid, sop, eop, err, port[1:0], in_ready[3:0]}
   typedef struct packed {
      logic [3:0] en;
      logic [3:0] v;
      logic [3:0] s;
      logic [3:0] e;
      logic       ordy;
      logic [9:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkv(input logic [3:0] en, input logic [3:0] v, input logic [3:0] s,
                                input logic [3:0] e, input logic ordy, input logic [9:0] exp);
      vec_t r;
      r.en = en; r.v = v; r.s = s; r.e = e; r.ordy = ordy; r.exp = exp;
      return r;
   endfunction

   function automatic logic [31:0] pdata(input int p, input int tag);
      return 32'hA000_0000 | (32'(p) << 16) | (32'(tag) & 32'h0000_FFFF);
   endfunction

   function automatic logic [9:0] outs();
      return {out_valid, out_sop, out_eop, out_err, out_port, in_ready};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] en, input logic [3:0] v, input logic [3:0] s,
                        input logic [3:0] e, input logic ordy, input int tag);
      cfg_port_en = en;
      in_valid    = v;
      in_sop      = s;
      in_eop      = e;
      out_ready   = ordy;
      for (int p = 0; p < NP; p++)
         in_data[p*DW +: DW] = pdata(p, tag);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int beat;
      logic ordy;

      // Arbitration order with bubbles, all ports requesting 2-beat packets
      vecs.push_back(mkv(4'hF, 4'hF, 4'hF, 4'h0, 1'b1, {4'b0000, 2'd0, 4'h0}));
      vecs.push_back(mkv(4'hF, 4'hF, 4'hF, 4'h0, 1'b1, {4'b1100, 2'd0, 4'h1}));
      vecs.push_back(mkv(4'hF, 4'hF, 4'hE, 4'h1, 1'b1, {4'b1010, 2'd0, 4'h1}));
      vecs.push_back(mkv(4'hF, 4'hE, 4'hE, 4'h0, 1'b1, {4'b0000, 2'd0, 4'h0}));
      vecs.push_back(mkv(4'hF, 4'hE, 4'hE, 4'h0, 1'b1, {4'b1100, 2'd1, 4'h2}));
      vecs.push_back(mkv(4'hF, 4'hE, 4'hC, 4'h2, 1'b1, {4'b1010, 2'd1, 4'h2}));
      vecs.push_back(mkv(4'hF, 4'hC, 4'hC, 4'h0, 1'b1, {4'b0000, 2'd1, 4'h0}));
      vecs.push_back(mkv(4'hF, 4'hC, 4'hC, 4'h0, 1'b1, {4'b1100, 2'd2, 4'h4}));
      vecs.push_back(mkv(4'hF, 4'hC, 4'h8, 4'h4, 1'b1, {4'b1010, 2'd2, 4'h4}));
      vecs.push_back(mkv(4'hF, 4'h8, 4'h8, 4'h0, 1'b1, {4'b0000, 2'd2, 4'h0}));
      vecs.push_back(mkv(4'hF, 4'h8, 4'h8, 4'h0, 1'b1, {4'b1100, 2'd3, 4'h8}));
      vecs.push_back(mkv(4'hF, 4'h8, 4'h0, 4'h8, 1'b1, {4'b1010, 2'd3, 4'h8}));
      vecs.push_back(mkv(4'hF, 4'h0, 4'h0, 4'h0, 1'b1, {4'b0000, 2'd3, 4'h0}));
      // Orphan beats on port 3 while idle
      vecs.push_back(mkv(4'hF, 4'h8, 4'h0, 4'h0, 1'b1, {4'b0000, 2'd3, 4'h8}));
      vecs.push_back(mkv(4'hF, 4'h8, 4'h0, 4'h0, 1'b1, {4'b0000, 2'd3, 4'h8}));
      vecs.push_back(mkv(4'hF, 4'h8, 4'h0, 4'h0, 1'b1, {4'b0000, 2'd3, 4'h8}));
      vecs.push_back(mkv(4'hF, 4'h0, 4'h0, 4'h0, 1'b1, {4'b0000, 2'd3, 4'h0}));
      // Port enables 1010, then en[1] dropped while port 1 is mid-packet
      vecs.push_back(mkv(4'hA, 4'hF, 4'hF, 4'h0, 1'b1, {4'b0000, 2'd3, 4'h0}));
      vecs.push_back(mkv(4'h8, 4'hF, 4'hF, 4'h0, 1'b1, {4'b1100, 2'd1, 4'h2}));
      vecs.push_back(mkv(4'h8, 4'hF, 4'hD, 4'h2, 1'b1, {4'b1010, 2'd1, 4'h2}));
      vecs.push_back(mkv(4'h8, 4'hD, 4'hD, 4'h0, 1'b1, {4'b0000, 2'd1, 4'h0}));
      vecs.push_back(mkv(4'h8, 4'hD, 4'hD, 4'h0, 1'b1, {4'b1100, 2'd3, 4'h8}));
      vecs.push_back(mkv(4'h8, 4'hD, 4'h5, 4'h8, 1'b1, {4'b1010, 2'd3, 4'h8}));
      vecs.push_back(mkv(4'h8, 4'h5, 4'h5, 4'h0, 1'b1, {4'b0000, 2'd3, 4'h0}));
      vecs.push_back(mkv(4'hF, 4'h0, 4'h0, 4'h0, 1'b1, {4'b0000, 2'd3, 4'h0}));

      reset_n = 1'b0;
      drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 0);
      #12;
      chk("reset.outs", 32'(outs()), 32'h0);
      chk("reset.data", out_data, 32'h0);
      chk("reset.stats", {stat_aborts, stat_orphans}, 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].en, vecs[i].v, vecs[i].s, vecs[i].e, vecs[i].ordy, i);
         #1;
         chk($sformatf("vec%0d.outs", i), 32'(outs()), 32'(vecs[i].exp));
         if (vecs[i].exp[9])
            chk($sformatf("vec%0d.data", i), out_data, pdata(int'(vecs[i].exp[5:4]), i));
         tick();
      end
      chk("orphans.cnt", 32'(stat_orphans), 32'd3);
      chk("orphans.aborts", 32'(stat_aborts), 32'd0);

      // 5-beat packet on port 1 under alternating backpressure
      drive(4'hF, 4'h2, 4'h2, 4'h0, 1'b1, 0);
      #1;
      chk("bp.idle", 32'(outs()), 32'h0 | 32'({4'b0000, 2'd3, 4'h0}));
      tick();
      beat = 0;
      ordy = 1'b1;
      for (int cyc = 0; cyc < 20 && beat < 5; cyc++) begin
         drive(4'hF, 4'h2, (beat == 0) ? 4'h2 : 4'h0, (beat == 4) ? 4'h2 : 4'h0, ordy, beat);
         #1;
         chk("bp.outs", 32'(outs()),
             32'({1'b1, beat == 0, beat == 4, 1'b0, 2'd1, 2'b00, ordy, 1'b0}));
         chk("bp.data", out_data, pdata(1, beat));
         tick();
         if (ordy) beat++;
         ordy = !ordy;
      end
      chk("bp.beats", 32'(beat), 32'd5);
      drive(4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 0);
      #1;
      chk("bp.after", 32'(outs()), 32'({4'b0000, 2'd1, 4'h0}));
      chk("bp.aborts", 32'(stat_aborts), 32'd0);
      tick();

      // Port 2 stalls: 255 idle cycles survive, 256 abort
      drive(4'hF, 4'h4, 4'h4, 4'h0, 1'b1, 0);
      tick();
      drive(4'hF, 4'h4, 4'h4, 4'h0, 1'b1, 0);
      #1;
      chk("stall.b0", 32'(outs()), 32'({4'b1100, 2'd2, 4'h4}));
      tick();
      drive(4'hF, 4'h4, 4'h0, 4'h0, 1'b1, 1);
      tick();
      drive(4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 0);
      repeat (SM - 1) tick();
      drive(4'hF, 4'h4, 4'h0, 4'h0, 1'b1, 2);
      #1;
      chk("stall.edge", 32'(outs()), 32'({4'b1000, 2'd2, 4'h4}));
      chk("stall.edge_data", out_data, pdata(2, 2));
      tick();
      chk("stall.edge_aborts", 32'(stat_aborts), 32'd0);
      drive(4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 0);
      repeat (SM - 1) tick();
      chk("stall.pre", 32'(outs()), 32'({4'b0000, 2'd2, 4'h0}));
      tick();
      chk("abort.outs", 32'(outs()), 32'({4'b1011, 2'd2, 4'h0}));
      chk("abort.data", out_data, 32'h0);
      chk("abort.cnt", 32'(stat_aborts), 32'd1);
      tick();
      chk("abort.hold", 32'(outs()), 32'({4'b1011, 2'd2, 4'h0}));
      out_ready = 1'b1;
      tick();
      drive(4'hF, 4'h4, 4'h4, 4'h0, 1'b1, 3);
      #1;
      chk("drain.sop", 32'(outs()), 32'({4'b0000, 2'd2, 4'h4}));
      tick();
      drive(4'hF, 4'h4, 4'h0, 4'h4, 1'b1, 4);
      #1;
      chk("drain.eop", 32'(outs()), 32'({4'b0000, 2'd2, 4'h4}));
      tick();
      drive(4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 0);
      #1;
      chk("drain.idle", 32'(outs()), 32'({4'b0000, 2'd2, 4'h0}));
      chk("drain.stats", {stat_aborts, stat_orphans}, {16'd1, 16'd3});
      tick();

      // Reset mid-packet on port 1, then port 0 wins first
      drive(4'hF, 4'h2, 4'h2, 4'h0, 1'b1, 0);
      tick();
      drive(4'hF, 4'h2, 4'h2, 4'h0, 1'b1, 0);
      #1;
      chk("rst.pass", 32'(outs()), 32'({4'b1100, 2'd1, 4'h2}));
      tick();
      drive(4'hF, 4'h2, 4'h0, 4'h0, 1'b1, 1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst.outs", 32'(outs()), 32'h0);
      chk("rst.data", out_data, 32'h0);
      chk("rst.stats", {stat_aborts, stat_orphans}, 32'h0);
      tick();
      reset_n = 1'b1;
      drive(4'hF, 4'h3, 4'h3, 4'h1, 1'b1, 0);
      #1;
      chk("rst.idle", 32'(outs()), 32'h0);
      tick();
      #1;
      chk("rst.port0", 32'(outs()), 32'({4'b1110, 2'd0, 4'h1}));
      chk("rst.port0_data", out_data, pdata(0, 0));
      tick();
      drive(4'hF, 4'h2, 4'h2, 4'h0, 1'b1, 0);
      tick();
      #1;
      chk("rst.port1", 32'(outs()), 32'({4'b1100, 2'd1, 4'h2}));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
